note_prefetch: RTL and testbench

NOTE_PREFETCH -- requirements
Module: note_prefetch

---
 rtl/buzzer_pkg.sv | 27 ++
 rtl/note_fifo.sv | 77 +++++++
 rtl/note_prefetch.sv | 184 ++++++++++++++++++
 tb/tb_note_prefetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// ============================================================================
//  Module      : buzzer_pkg
//  Description : Shared bus constants, prefetcher state type and note fields.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package buzzer_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int BEAT_W = 4;
  localparam int TUNE_W = 8;
  localparam int NOTE_W = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADDR       = 3'd1,
    S_DATA       = 3'd2,
    S_WAIT_SPACE = 3'd3,
    S_DRAIN      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/note_fifo.sv
// ============================================================================
//  Module      : note_fifo
//  Description : Power-of-two note FIFO with flush and free-entry count.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module note_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign free     = CW'(DEPTH) - cnt_q;
  assign pop_data = empty ? '0 : mem_q[rd_q];

  always_comb begin
    // A simultaneous pop frees the slot the push needs, even when full.
    do_push = push & (~full | pop);
    do_pop  = pop & ~empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/note_prefetch.sv
// ============================================================================
//  Module      : note_prefetch
//  Description : AHB-Lite song-note prefetcher feeding a note FIFO.
//                Looping is built only with NOTE_PREFETCH_LOOP_EN defined.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module note_prefetch
  import buzzer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] END_NOTE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] base_addr,
  input  logic        loop_en,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic        note_valid,
  input  logic        note_ready,
  output logic [15:0] note_data,
  output logic        busy,
  output logic        song_end
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FREE_PAIR = CW'(2);
  localparam logic [CW:0]    ROOM_PAIR = (CW+1)'(2);
  localparam logic [CW:0]    ROOM_WORD = (CW+1)'(3);

  state_e        state_q, state_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [31:0]   haddr_q, haddr_d;
  logic          hi_pend_q, hi_pend_d;
  logic [15:0]   hi_note_q, hi_note_d;
  logic          stop_pend_q, stop_pend_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_empty, unused_fifo_full;
  logic [15:0]   push_data;
  logic [CW-1:0] fifo_free;
  logic [CW:0]   room;
  logic          end_hit;

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NOTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (note_data),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  assign note_valid = ~fifo_empty;
  assign fifo_pop   = note_valid & note_ready;
  assign room       = {1'b0, fifo_free} + {{CW{1'b0}}, fifo_pop};
  assign HADDR      = haddr_q;
  assign HTRANS     = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE     = 1'b0;
  assign busy       = (state_q != S_IDLE);

`ifndef NOTE_PREFETCH_LOOP_EN
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hi_pend_d   = hi_pend_q;
    hi_note_d   = hi_note_q;
    stop_pend_d = stop_pend_q;
    fifo_push   = 1'b0;
    push_data   = HRDATA[15:0];
    fifo_flush  = 1'b0;
    song_end    = 1'b0;
    end_hit     = 1'b0;

    if (start) begin
      fifo_flush  = 1'b1;
      ptr_d       = base_addr;
      hi_pend_d   = 1'b0;
      stop_pend_d = 1'b0;
      state_d     = S_ADDR;
    end else if (stop) begin
      fifo_flush = 1'b1;
      hi_pend_d  = 1'b0;
      // An outstanding data phase must still see HREADY before the bus is released.
      if (state_q == S_DATA && !hi_pend_q && !HREADY) begin
        stop_pend_d = 1'b1;
      end else begin
        stop_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
    end else begin
      case (state_q)
        S_ADDR: if (HREADY) state_d = S_DATA;
        S_DATA: begin
          if (stop_pend_q) begin
            if (HREADY) begin
              stop_pend_d = 1'b0;
              state_d     = S_IDLE;
            end
          end else if (hi_pend_q) begin
            hi_pend_d = 1'b0;
            if (hi_note_q == END_NOTE) begin
              end_hit = 1'b1;
            end else begin
              fifo_push = 1'b1;
              push_data = hi_note_q;
              ptr_d     = ptr_q + 32'd4;
              state_d   = (room >= ROOM_WORD) ? S_ADDR : S_WAIT_SPACE;
            end
          end else if (HREADY) begin
            if (HRDATA[15:0] == END_NOTE) begin
              end_hit = 1'b1;
            end else begin
              fifo_push = 1'b1;
              hi_note_d = HRDATA[31:16];
              hi_pend_d = 1'b1;
            end
          end
        end
        S_WAIT_SPACE: if (fifo_free >= FREE_PAIR) state_d = S_ADDR;
        S_DRAIN: begin
          if (fifo_empty) begin
            song_end = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = state_q;
      endcase

      if (end_hit) begin
`ifdef NOTE_PREFETCH_LOOP_EN
        if (loop_en) begin
          ptr_d   = base_addr;
          state_d = (room >= ROOM_PAIR) ? S_ADDR : S_WAIT_SPACE;
        end else begin
          state_d = S_DRAIN;
        end
`else
        state_d = S_DRAIN;
`endif
      end
    end

    haddr_d = (state_d == S_ADDR) ? ptr_d : haddr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      haddr_q     <= '0;
      hi_pend_q   <= 1'b0;
      hi_note_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      haddr_q     <= haddr_d;
      hi_pend_q   <= hi_pend_d;
      hi_note_q   <= hi_note_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_prefetch.sv
// ============================================================================
//  Module      : tb_note_prefetch
//  Description : Self-checking bench for note_prefetch against a song model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_note_prefetch;

  localparam logic [15:0] END = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en, HREADY, note_ready;
  logic [31:0] base_addr, HADDR, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, note_valid, busy, song_end;
  logic [15:0] note_data;

  note_prefetch #(.DEPTH(4), .END_NOTE(END)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
    .loop_en(loop_en), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .note_valid(note_valid),
    .note_ready(note_ready), .note_data(note_data), .busy(busy), .song_end(song_end)
  );

  initial forever #5 clk = ~clk;

  // Slave memory: 1 KB, read data follows the accepted address phase.
  logic [31:0] mem [0:255];
  logic [31:0] dph_addr = 32'h0;
  assign HRDATA = mem[dph_addr[9:2]];

  // Bus/consumer monitor
  logic [15:0] pop_q[$];
  logic [31:0] fetch_q[$];
  int          cyc = 0, last_pop_cyc = 0, song_end_cyc = 0, song_end_cnt = 0;
  int          stab_err = 0, stall_seen = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  logic [1:0]  stall_trans = 2'b00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (HTRANS == 2'b10 && HREADY) begin
        fetch_q.push_back(HADDR);
        dph_addr <= HADDR;
      end
      if (note_valid && note_ready) begin
        pop_q.push_back(note_data);
        last_pop_cyc <= cyc;
      end
      if (song_end) begin
        song_end_cnt <= song_end_cnt + 1;
        song_end_cyc <= cyc;
      end
      if (stall_prev) begin
        stall_seen <= stall_seen + 1;
        if (HTRANS != stall_trans || HADDR != stall_addr) stab_err <= stab_err + 1;
      end
    end
    stall_prev  <= !rst && !start && !stop && HTRANS == 2'b10 && !HREADY;
    stall_addr  <= HADDR;
    stall_trans <= HTRANS;
  end

  int n_cmp = 0, n_err = 0;
  int hr_mode = 0, nr_mode = 0, pat = 0;
  logic [15:0] exp_notes[$];
  logic [31:0] exp_addrs[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // hr_mode: 0 always ready, 1 five low then one high, 2 random, 3 manual
  task automatic tick();
    @(posedge clk);
    #1;
    case (hr_mode)
      0: HREADY = 1'b1;
      1: begin pat = (pat + 1) % 6; HREADY = (pat == 0); end
      2: HREADY = ($urandom_range(0, 9) < 7);
      default: ;
    endcase
    if (nr_mode != 0) note_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    mem[a[9:2]] = d;
  endtask

  function automatic logic [15:0] rnd_nz();
    return 16'($urandom_range(1, 65535));
  endfunction

  task automatic make_song(input logic [31:0] base, input int nw, input bit end_hi);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < nw; i++) begin
      mem_wr(a, {rnd_nz(), rnd_nz()});
      a = a + 32'd4;
    end
    if (end_hi) mem_wr(a, {END, rnd_nz()});
    else        mem_wr(a, {16'($urandom), END});
  endtask

  // Song semantics: halves low-then-high, stop at the first END marker.
  task automatic model_song(input logic [31:0] base);
    logic [31:0] a, w;
    exp_notes.delete();
    exp_addrs.delete();
    a = base;
    for (int i = 0; i < 256; i++) begin
      w = mem[a[9:2]];
      exp_addrs.push_back(a);
      if (w[15:0] == END) break;
      exp_notes.push_back(w[15:0]);
      if (w[31:16] == END) break;
      exp_notes.push_back(w[31:16]);
      a = a + 32'd4;
    end
  endtask

  task automatic pulse_start(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_song_end(input int budget);
    int b, n;
    b = song_end_cnt;
    n = 0;
    while (song_end_cnt == b && n < budget) begin
      tick();
      n++;
    end
    check_value("song_end_seen", 32'(song_end_cnt - b), 32'd1);
  endtask

  task automatic cmp_stream(input int pb, input int fb);
    check_value("note_count", 32'(pop_q.size() - pb), 32'(exp_notes.size()));
    for (int i = 0; i < exp_notes.size() && pb + i < pop_q.size(); i++)
      check_value($sformatf("note[%0d]", i), 32'(pop_q[pb + i]), 32'(exp_notes[i]));
    check_value("fetch_count", 32'(fetch_q.size() - fb), 32'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && fb + i < fetch_q.size(); i++)
      check_value($sformatf("haddr[%0d]", i), fetch_q[fb + i], exp_addrs[i]);
  endtask

  task automatic run_song(input logic [31:0] base, input int nw, input bit eh,
                          input int hm, input int nm);
    int pb, fb;
    make_song(base, nw, eh);
    model_song(base);
    hr_mode = hm;
    nr_mode = nm;
    pb = pop_q.size();
    fb = fetch_q.size();
    pulse_start(base);
    wait_song_end(3000);
    check_value("idle_after_song", 32'(busy), 32'd0);
    cmp_stream(pb, fb);
  endtask

  initial begin
    int pb, fb, n, lat, se, sb;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    HREADY = 1'b1; note_ready = 1'b0; base_addr = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_htrans", 32'(HTRANS), 32'd0);
    check_value("rst_haddr", HADDR, 32'd0);
    check_value("rst_hwrite", 32'(HWRITE), 32'd0);
    check_value("rst_note_valid", 32'(note_valid), 32'd0);
    check_value("rst_note_data", 32'(note_data), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_song_end", 32'(song_end), 32'd0);
    rst = 1'b0;
    tick();

    // Directed three-note song with literal expectations
    mem_wr(32'h100, 32'h0203_0101);
    mem_wr(32'h104, 32'h0000_0405);
    hr_mode = 0; nr_mode = 0; note_ready = 1'b1;
    pb = pop_q.size(); fb = fetch_q.size();
    pulse_start(32'h100);
    lat = 1;
    while (!note_valid && lat < 20) begin tick(); lat++; end
    check_value("first_note_latency", 32'(lat), 32'd3);
    wait_song_end(100);
    check_value("dir_note_count", 32'(pop_q.size() - pb), 32'd3);
    if (pop_q.size() - pb >= 3) begin
      check_value("dir_note0", 32'(pop_q[pb]),     32'h0101);
      check_value("dir_note1", 32'(pop_q[pb + 1]), 32'h0203);
      check_value("dir_note2", 32'(pop_q[pb + 2]), 32'h0405);
    end
    check_value("dir_fetch_count", 32'(fetch_q.size() - fb), 32'd2);
    if (fetch_q.size() - fb >= 2) begin
      check_value("dir_haddr0", fetch_q[fb],     32'h100);
      check_value("dir_haddr1", fetch_q[fb + 1], 32'h104);
    end
    check_value("song_end_after_pop", 32'(song_end_cyc - last_pop_cyc), 32'd1);
    tick();
    check_value("song_end_one_cycle", 32'(song_end), 32'd0);
    check_value("dir_idle", 32'(busy), 32'd0);

    // Back-pressure: FIFO fills after two fetches, third fetch after two pops
    make_song(32'h200, 5, 1'b0);
    model_song(32'h200);
    hr_mode = 0; nr_mode = 0; note_ready = 1'b0;
    pb = pop_q.size(); fb = fetch_q.size();
    pulse_start(32'h200);
    repeat (20) tick();
    check_value("bp_fetches_full", 32'(fetch_q.size() - fb), 32'd2);
    check_value("bp_htrans_idle", 32'(HTRANS), 32'd0);
    check_value("bp_busy", 32'(busy), 32'd1);
    note_ready = 1'b1;
    tick();
    tick();
    note_ready = 1'b0;
    repeat (10) tick();
    check_value("bp_third_fetch", 32'(fetch_q.size() - fb), 32'd3);
    nr_mode = 1;
    wait_song_end(1000);
    cmp_stream(pb, fb);

    // Long HREADY stalls in address and data phases
    sb = stall_seen;
    run_song(32'h180, 4, 1'b1, 1, 1);
    check_value("stall_exercised", 32'(stall_seen > sb), 32'd1);
    check_value("stall_bus_stable", 32'(stab_err), 32'd0);

    // Randomized songs, including END in the low half
    for (int t = 0; t < 6; t++)
      run_song({22'h0, 8'($urandom_range(0, 191)), 2'b00}, int'($urandom_range(0, 5)),
               1'($urandom_range(0, 1)), 2, 1);

    // Stop while the data phase is stalled
    make_song(32'h200, 8, 1'b1);
    hr_mode = 3; HREADY = 1'b1; nr_mode = 0; note_ready = 1'b0;
    pulse_start(32'h200);
    n = 0;
    while (!(HTRANS == 2'b10 && HADDR == 32'h204) && n < 30) begin tick(); n++; end
    check_value("stop_second_addr", 32'(n < 30), 32'd1);
    tick();
    check_value("stop_fifo_loaded", 32'(note_valid), 32'd1);
    HREADY = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_value("stop_flushed", 32'(note_valid), 32'd0);
    tick();
    tick();
    check_value("stop_waits_hready", 32'(busy), 32'd1);
    check_value("stop_htrans_idle", 32'(HTRANS), 32'd0);
    HREADY = 1'b1;
    tick();
    check_value("stop_idle", 32'(busy), 32'd0);
    tick();
    check_value("stop_data_discarded", 32'(note_valid), 32'd0);

    // Asynchronous reset during a stalled address phase
    HREADY = 1'b0;
    pulse_start(32'h300);
    check_value("arst_in_addr", 32'(HTRANS), 32'd2);
    #3 rst = 1'b1;
    #1;
    check_value("arst_htrans", 32'(HTRANS), 32'd0);
    check_value("arst_haddr", HADDR, 32'd0);
    check_value("arst_busy", 32'(busy), 32'd0);
    check_value("arst_note_valid", 32'(note_valid), 32'd0);
    tick();
    rst = 1'b0;
    hr_mode = 0;
    tick();

`ifdef NOTE_PREFETCH_LOOP_EN
    // Looping two-word song repeats without song_end
    mem_wr(32'h380, {rnd_nz(), rnd_nz()});
    mem_wr(32'h384, {END, rnd_nz()});
    model_song(32'h380);
    loop_en = 1'b1; hr_mode = 2; nr_mode = 1;
    se = song_end_cnt;
    pb = pop_q.size(); fb = fetch_q.size();
    pulse_start(32'h380);
    n = 0;
    while (pop_q.size() - pb < 12 && n < 2000) begin tick(); n++; end
    check_value("loop_notes_seen", 32'(pop_q.size() - pb >= 12), 32'd1);
    for (int i = 0; i < 12 && pb + i < pop_q.size(); i++)
      check_value($sformatf("loop_note[%0d]", i), 32'(pop_q[pb + i]), 32'(exp_notes[i % 3]));
    for (int i = 0; i < 5 && fb + i < fetch_q.size(); i++)
      check_value($sformatf("loop_haddr[%0d]", i), fetch_q[fb + i], exp_addrs[i % 2]);
    check_value("loop_no_song_end", 32'(song_end_cnt - se), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check_value("loop_stopped", 32'(busy), 32'd0);
    check_value("loop_stop_empty", 32'(note_valid), 32'd0);
    loop_en = 1'b0;
`else
    // Without the loop build, loop_en must not affect an ending song
    loop_en = 1'b1;
    run_song(32'h380, 1, 1'b1, 2, 1);
    loop_en = 1'b0;
`endif

    check_value("final_bus_stable", 32'(stab_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
